hazard_fwd_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage miniRV pipeline; the producer side of the ID/EX register's `flush`, `rd1_op`/`rd2_op` and `rd1_f`/`rd2_f` inputs.
- Compares ID-stage source registers against the EX, MEM and WB destinations and selects forwarded operands.
- Inserts exactly one bubble on a load-use hazard and flushes IF/ID and ID/EX on an EX-stage redirect.
- Holds a one-entry write history so a value retired last cycle is still bypassed while the register file write settles.

---
 rtl/hazard_fwd_ctrl_if.sv | 46 ++++
 rtl/hazard_fwd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding bundle between the miniRV pipeline and hazard_fwd_ctrl.
// master: pipeline side (drives stage info, consumes stall/flush/forward).
// slave : the controller.
interface hazard_fwd_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  ex_wR;
  logic        ex_we;
  logic [1:0]  ex_wd_sel;
  logic [31:0] ex_wD;
  logic        ex_redirect;
  logic [4:0]  mem_wR;
  logic        mem_we;
  logic [31:0] mem_wD;
  logic [4:0]  wb_wR;
  logic        wb_we;
  logic [31:0] wb_wD;
  logic        stall_pc;
  logic        stall_if_id;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        rd1_op;
  logic        rd2_op;
  logic [31:0] rd1_f;
  logic [31:0] rd2_f;

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2,
    output ex_wR, ex_we, ex_wd_sel, ex_wD, ex_redirect,
    output mem_wR, mem_we, mem_wD,
    output wb_wR, wb_we, wb_wD,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    input  rd1_op, rd2_op, rd1_f, rd2_f
  );

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2,
    input  ex_wR, ex_we, ex_wd_sel, ex_wD, ex_redirect,
    input  mem_wR, mem_we, mem_wD,
    input  wb_wR, wb_we, wb_wD,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    output rd1_op, rd2_op, rd1_f, rd2_f
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage miniRV pipeline.
// Optional build macro HAZARD_PERF_CNT_EN adds o_stall_cnt / o_flush_cnt.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | normal issue; load-use detection and redirect flush active
// S_LDSTALL | bubble cycle after a load-use stall; load now forwards from MEM
module hazard_fwd_ctrl #(
  parameter logic [1:0] LOAD_SEL = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_fwd_ctrl_if.slave    bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         o_stall_cnt,
  output logic [31:0]         o_flush_cnt
`endif
);

  typedef enum logic {S_RUN, S_LDSTALL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_hist_vld;
  logic [4:0]  r_hist_wR;
  logic [31:0] r_hist_wD;

  logic        w_stall_pc;
  logic        w_stall_if_id;
  logic        w_flush_if_id;
  logic        w_flush_id_ex;
  logic        w_ex_load;
  logic        w_ld_use;
  logic        w_ex_hit1, w_ex_hit2;
  logic        w_mem_hit1, w_mem_hit2;
  logic        w_wb_hit1, w_wb_hit2;
  logic        w_hist_hit1, w_hist_hit2;
  logic [32:0] w_fwd1, w_fwd2;

  function automatic logic f_hit(input logic re, input logic [4:0] rs,
                                 input logic we, input logic [4:0] wr);
    return re && (rs != 5'd0) && we && (rs == wr);
  endfunction

  // Highest-priority hit wins; result is {use_forward, data}.
  function automatic logic [32:0] f_sel(input logic hx, input logic hm,
                                        input logic hw, input logic hh,
                                        input logic [31:0] dx, input logic [31:0] dm,
                                        input logic [31:0] dw, input logic [31:0] dh);
    if (hx)      return {1'b1, dx};
    else if (hm) return {1'b1, dm};
    else if (hw) return {1'b1, dw};
    else if (hh) return {1'b1, dh};
    else         return 33'd0;
  endfunction

  assign w_ex_load   = (bus.ex_wd_sel == LOAD_SEL);
  assign w_ex_hit1   = f_hit(bus.id_re1, bus.id_rs1, bus.ex_we,  bus.ex_wR);
  assign w_ex_hit2   = f_hit(bus.id_re2, bus.id_rs2, bus.ex_we,  bus.ex_wR);
  assign w_mem_hit1  = f_hit(bus.id_re1, bus.id_rs1, bus.mem_we, bus.mem_wR);
  assign w_mem_hit2  = f_hit(bus.id_re2, bus.id_rs2, bus.mem_we, bus.mem_wR);
  assign w_wb_hit1   = f_hit(bus.id_re1, bus.id_rs1, bus.wb_we,  bus.wb_wR);
  assign w_wb_hit2   = f_hit(bus.id_re2, bus.id_rs2, bus.wb_we,  bus.wb_wR);
  assign w_hist_hit1 = f_hit(bus.id_re1, bus.id_rs1, r_hist_vld, r_hist_wR);
  assign w_hist_hit2 = f_hit(bus.id_re2, bus.id_rs2, r_hist_vld, r_hist_wR);
  assign w_ld_use    = (w_ex_hit1 | w_ex_hit2) & w_ex_load;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state and stall/flush decode; redirect outranks load-use
  always_comb begin
    w_state_nxt   = r_state;
    w_stall_pc    = 1'b0;
    w_stall_if_id = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.ex_redirect) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (w_ld_use) begin
          w_stall_pc    = 1'b1;
          w_stall_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
          w_state_nxt   = S_LDSTALL;
        end
      end
      S_LDSTALL: begin
        // EX holds the bubble we inserted, so load-use is not re-checked.
        w_state_nxt = S_RUN;
        if (bus.ex_redirect) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // One-entry history of last cycle's register-file write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_vld <= 1'b0;
      r_hist_wR  <= 5'd0;
      r_hist_wD  <= 32'd0;
    end else begin
      r_hist_vld <= bus.wb_we && (bus.wb_wR != 5'd0);
      r_hist_wR  <= bus.wb_wR;
      r_hist_wD  <= bus.wb_wD;
    end
  end

  // Operand forwarding: EX (non-load) > MEM > WB > history
  always_comb begin
    w_fwd1 = f_sel(w_ex_hit1 & ~w_ex_load, w_mem_hit1, w_wb_hit1, w_hist_hit1,
                   bus.ex_wD, bus.mem_wD, bus.wb_wD, r_hist_wD);
    w_fwd2 = f_sel(w_ex_hit2 & ~w_ex_load, w_mem_hit2, w_wb_hit2, w_hist_hit2,
                   bus.ex_wD, bus.mem_wD, bus.wb_wD, r_hist_wD);
  end

  // Outputs are forced low for the whole time reset is held.
  assign bus.stall_pc    = rst_n & w_stall_pc;
  assign bus.stall_if_id = rst_n & w_stall_if_id;
  assign bus.flush_if_id = rst_n & w_flush_if_id;
  assign bus.flush_id_ex = rst_n & w_flush_id_ex;
  assign bus.rd1_op      = rst_n & w_fwd1[32];
  assign bus.rd2_op      = rst_n & w_fwd2[32];
  assign bus.rd1_f       = rst_n ? w_fwd1[31:0] : 32'd0;
  assign bus.rd2_f       = rst_n ? w_fwd2[31:0] : 32'd0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Count load-use stall entries and redirect flushes (wrap on overflow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if ((r_state == S_RUN) && (w_state_nxt == S_LDSTALL))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_if_id)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  localparam logic [1:0] LOAD_SEL = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_fwd_ctrl #(.LOAD_SEL(LOAD_SEL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: "the previous cycle started a load-use stall",
  // last retired write, and event tallies.
  bit          m_in_bubble;
  bit          m_hv;
  logic [4:0]  m_hR;
  logic [31:0] m_hD;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Is the instruction in EX a load whose destination ID reads?
  function automatic bit m_ld_use();
    if (!bus.ex_we || bus.ex_wR == 5'd0 || bus.ex_wd_sel != LOAD_SEL) return 1'b0;
    return (bus.id_re1 && bus.id_rs1 == bus.ex_wR) || (bus.id_re2 && bus.id_rs2 == bus.ex_wR);
  endfunction

  // Walk the producers from youngest to oldest; first matching writer supplies the value.
  function automatic logic [32:0] m_fwd(input logic re, input logic [4:0] rs);
    logic        we[4];
    logic [4:0]  wr[4];
    logic [31:0] wd[4];
    we[0] = bus.ex_we && (bus.ex_wd_sel != LOAD_SEL); wr[0] = bus.ex_wR;  wd[0] = bus.ex_wD;
    we[1] = bus.mem_we;                               wr[1] = bus.mem_wR; wd[1] = bus.mem_wD;
    we[2] = bus.wb_we;                                wr[2] = bus.wb_wR;  wd[2] = bus.wb_wD;
    we[3] = m_hv;                                     wr[3] = m_hR;       wd[3] = m_hD;
    if (!re || rs == 5'd0) return 33'd0;
    for (int i = 0; i < 4; i++)
      if (we[i] && wr[i] == rs) return {1'b1, wd[i]};
    return 33'd0;
  endfunction

  task automatic check_all();
    logic [32:0] f1, f2;
    bit stall, flush;
    f1    = m_fwd(bus.id_re1, bus.id_rs1);
    f2    = m_fwd(bus.id_re2, bus.id_rs2);
    flush = rst_n && bus.ex_redirect;
    stall = rst_n && !m_in_bubble && !bus.ex_redirect && m_ld_use();
    chk("stall_pc",    {31'd0, bus.stall_pc},    {31'd0, stall});
    chk("stall_if_id", {31'd0, bus.stall_if_id}, {31'd0, stall});
    chk("flush_if_id", {31'd0, bus.flush_if_id}, {31'd0, flush});
    chk("flush_id_ex", {31'd0, bus.flush_id_ex}, {31'd0, flush | stall});
    chk("rd1_op", {31'd0, bus.rd1_op}, {31'd0, rst_n & f1[32]});
    chk("rd2_op", {31'd0, bus.rd2_op}, {31'd0, rst_n & f2[32]});
    chk("rd1_f",  bus.rd1_f, rst_n ? f1[31:0] : 32'd0);
    chk("rd2_f",  bus.rd2_f, rst_n ? f2[31:0] : 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, rst_n ? m_scnt : 32'd0);
    chk("flush_cnt", flush_cnt, rst_n ? m_fcnt : 32'd0);
`endif
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  // Advance one clock: update the model at the edge, return at the next negedge.
  task automatic adv();
    bit lu;
    @(posedge clk);
    lu = m_ld_use();
    if (!rst_n) begin
      m_in_bubble = 1'b0; m_hv = 1'b0; m_hR = '0; m_hD = '0;
      m_scnt = '0; m_fcnt = '0;
    end else begin
      if (!m_in_bubble && !bus.ex_redirect && lu) begin
        m_in_bubble = 1'b1;
        m_scnt++;
      end else begin
        m_in_bubble = 1'b0;
      end
      if (bus.ex_redirect) m_fcnt++;
      m_hv = bus.wb_we && (bus.wb_wR != 5'd0);
      m_hR = bus.wb_wR;
      m_hD = bus.wb_wD;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_re1 = 1'b0; bus.id_re2 = 1'b0;
    bus.ex_wR = '0; bus.ex_we = 1'b0; bus.ex_wd_sel = 2'b00; bus.ex_wD = '0;
    bus.ex_redirect = 1'b0;
    bus.mem_wR = '0; bus.mem_we = 1'b0; bus.mem_wD = '0;
    bus.wb_wR = '0; bus.wb_we = 1'b0; bus.wb_wD = '0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    bus.ex_we = 1'b1; bus.ex_wR = r; bus.ex_wd_sel = LOAD_SEL; bus.ex_wD = 32'hDEAD_0000;
    bus.id_rs2 = r; bus.id_re2 = 1'b1;
  endtask

  initial begin
    m_in_bubble = 1'b0; m_hv = 1'b0; m_hR = '0; m_hD = '0; m_scnt = '0; m_fcnt = '0;

    // Reset with live hazards on the inputs: every output must be 0.
    rst_n = 1'b0;
    idle();
    set_load_use(5'd4);
    bus.ex_redirect = 1'b1;
    bus.id_rs1 = 5'd4; bus.id_re1 = 1'b1; bus.mem_we = 1'b1; bus.mem_wR = 5'd4; bus.mem_wD = 32'h77;
    settle();
    chk("rst_flush", {31'd0, bus.flush_id_ex}, 32'd0);
    chk("rst_rd1_op", {31'd0, bus.rd1_op}, 32'd0);
    adv();
    rst_n = 1'b1;
    idle();
    settle();
    adv();

    // EX forward beats MEM.
    idle();
    bus.ex_we = 1'b1; bus.ex_wR = 5'd5; bus.ex_wd_sel = 2'b00; bus.ex_wD = 32'h1234;
    bus.id_rs1 = 5'd5; bus.id_re1 = 1'b1;
    bus.mem_we = 1'b1; bus.mem_wR = 5'd5; bus.mem_wD = 32'h9;
    settle();
    chk("exfwd_op", {31'd0, bus.rd1_op}, 32'd1);
    chk("exfwd_f", bus.rd1_f, 32'h1234);
    chk("exfwd_nostall", {31'd0, bus.stall_pc}, 32'd0);
    adv();

    // Load-use: stall, then bubble cycle forwarding from MEM.
    idle();
    set_load_use(5'd7);
    settle();
    chk("lu_stall_pc", {31'd0, bus.stall_pc}, 32'd1);
    chk("lu_stall_if_id", {31'd0, bus.stall_if_id}, 32'd1);
    chk("lu_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd1);
    adv();
    bus.mem_we = 1'b1; bus.mem_wR = 5'd7; bus.mem_wD = 32'hCAFE;
    settle();
    chk("ldstall_nostall", {31'd0, bus.stall_pc}, 32'd0);
    chk("ldstall_rd2_op", {31'd0, bus.rd2_op}, 32'd1);
    chk("ldstall_rd2_f", bus.rd2_f, 32'hCAFE);
    adv();
    settle();
    chk("back_to_run_stall", {31'd0, bus.stall_pc}, 32'd1);
    adv();
    idle();
    settle();
    adv();

    // Redirect outranks load-use; FSM stays in RUN.
    idle();
    set_load_use(5'd9);
    bus.ex_redirect = 1'b1;
    settle();
    chk("redir_flush_if_id", {31'd0, bus.flush_if_id}, 32'd1);
    chk("redir_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd1);
    chk("redir_stall_pc", {31'd0, bus.stall_pc}, 32'd0);
    adv();
    bus.ex_redirect = 1'b0;
    settle();
    chk("redir_then_run", {31'd0, bus.stall_pc}, 32'd1);
    adv();
    // Redirect during the bubble cycle still flushes.
    bus.ex_redirect = 1'b1;
    settle();
    chk("ldstall_redir_flush", {31'd0, bus.flush_if_id}, 32'd1);
    adv();

    // x0 is never forwarded.
    idle();
    bus.id_rs1 = 5'd0; bus.id_re1 = 1'b1;
    bus.ex_we = 1'b1; bus.ex_wR = 5'd0; bus.ex_wD = 32'hFF;
    settle();
    chk("x0_rd1_op", {31'd0, bus.rd1_op}, 32'd0);
    adv();

    // History bypass of last cycle's WB write.
    idle();
    bus.wb_we = 1'b1; bus.wb_wR = 5'd3; bus.wb_wD = 32'hAB;
    settle();
    adv();
    idle();
    bus.id_rs1 = 5'd3; bus.id_re1 = 1'b1;
    settle();
    chk("hist_rd1_op", {31'd0, bus.rd1_op}, 32'd1);
    chk("hist_rd1_f", bus.rd1_f, 32'hAB);
    adv();

    // Reset in the middle of a load-use stall.
    idle();
    set_load_use(5'd6);
    bus.wb_we = 1'b1; bus.wb_wR = 5'd3; bus.wb_wD = 32'h55;
    settle();
    adv();
    idle();
    set_load_use(5'd6);
    bus.id_rs1 = 5'd3; bus.id_re1 = 1'b1;
    settle();
    chk("pre_rst_hist", bus.rd1_f, 32'h55);
    rst_n = 1'b0;
    settle();
    chk("midrst_stall", {31'd0, bus.stall_pc}, 32'd0);
    chk("midrst_rd1_op", {31'd0, bus.rd1_op}, 32'd0);
    adv();
    rst_n = 1'b1;
    idle();
    bus.id_rs1 = 5'd3; bus.id_re1 = 1'b1;
    settle();
    chk("postrst_hist_invalid", {31'd0, bus.rd1_op}, 32'd0);
    adv();
    set_load_use(5'd6);
    settle();
    chk("postrst_run", {31'd0, bus.stall_pc}, 32'd1);
    adv();
    idle();
    settle();
    adv();

`ifdef HAZARD_PERF_CNT_EN
    // 3 load-use events and 2 redirects from a clean reset.
    rst_n = 1'b0;
    idle();
    adv();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(); set_load_use(5'd10 + 5'(k)); settle(); adv();
      idle(); settle(); adv();
    end
    for (int k = 0; k < 2; k++) begin
      idle(); bus.ex_redirect = 1'b1; settle(); adv();
    end
    idle();
    settle();
    chk("cnt_stall", stall_cnt, 32'd3);
    chk("cnt_flush", flush_cnt, 32'd2);
    adv();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rst_n           = ($urandom_range(0, 59) != 0);
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_re1      = 1'($urandom_range(0, 1));
      bus.id_re2      = 1'($urandom_range(0, 1));
      bus.ex_wR       = 5'($urandom_range(0, 3));
      bus.ex_we       = 1'($urandom_range(0, 1));
      bus.ex_wd_sel   = 2'($urandom_range(0, 3));
      bus.ex_wD       = $urandom;
      bus.ex_redirect = ($urandom_range(0, 7) == 0);
      bus.mem_wR      = 5'($urandom_range(0, 3));
      bus.mem_we      = 1'($urandom_range(0, 1));
      bus.mem_wD      = $urandom;
      bus.wb_wR       = 5'($urandom_range(0, 3));
      bus.wb_we       = 1'($urandom_range(0, 1));
      bus.wb_wD       = $urandom;
      settle();
      adv();
    end
    rst_n = 1'b1;
    idle();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
